// File: rtl/pass_entry_ctrl.sv
// rtl/pass_entry_ctrl.sv - password overlay sequencer: keypad FSM, timers and 8-column text buffer
module pass_entry_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter logic [15:0] CODE          = 16'h1234,
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned ENTRY_TIMEOUT = 10,
  parameter int unsigned GRANT_SECS    = 3,
  parameter int unsigned DENY_SECS     = 2,
  parameter int unsigned LOCK_SECS     = 30
) (
  input  logic       main_clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [2:0] col_idx,
  output logic [6:0] col_char,
  output logic       unlock,
  output logic       locked,
  output logic [2:0] state,
  output logic [1:0] fail_cnt
);

  typedef enum logic [2:0] {
    S_PROMPT  = 3'd0,
    S_ENTRY   = 3'd1,
    S_GRANTED = 3'd2,
    S_DENIED  = 3'd3,
    S_LOCKED  = 3'd4
  } state_e;

  localparam int unsigned CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] TICK_LAST   = CW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    ENTRY_LAST  = 8'(ENTRY_TIMEOUT - 1);
  localparam logic [7:0]    GRANT_LAST  = 8'(GRANT_SECS - 1);
  localparam logic [7:0]    DENY_LAST   = 8'(DENY_SECS - 1);
  localparam logic [7:0]    LOCK_LAST   = 8'(LOCK_SECS - 1);
  localparam logic [1:0]    FAIL_LIMIT  = 2'(MAX_FAILS);

  state_e          state_q, state_d;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [7:0]      sec_q, sec_d;
  logic            blink_q, blink_d;
  logic [2:0]      digit_cnt_q, digit_cnt_d;
  logic [3:0][3:0] digits_q, digits_d;
  logic [1:0]      fail_q, fail_d;
  logic            unlock_q, unlock_d;

  logic tick;
  logic key_digit;
  logic code_ok;

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign key_digit = key_valid && (key_code <= 4'd9);
  assign code_ok   = (digit_cnt_q == 3'd4) &&
                     ({digits_q[0], digits_q[1], digits_q[2], digits_q[3]} == CODE);

  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PROMPT;
      tick_cnt_q  <= '0;
      sec_q       <= '0;
      blink_q     <= 1'b0;
      digit_cnt_q <= '0;
      digits_q    <= '0;
      fail_q      <= '0;
      unlock_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      sec_q       <= sec_d;
      blink_q     <= blink_d;
      digit_cnt_q <= digit_cnt_d;
      digits_q    <= digits_d;
      fail_q      <= fail_d;
      unlock_q    <= unlock_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    sec_d       = tick ? sec_q + 8'd1 : sec_q;
    blink_d     = blink_q;
    digit_cnt_d = digit_cnt_q;
    digits_d    = digits_q;
    fail_d      = fail_q;
    unlock_d    = 1'b0;

    unique case (state_q)
      S_PROMPT: begin
        if (tick) blink_d = ~blink_q;
        if (key_digit) begin
          state_d     = S_ENTRY;
          digits_d[0] = key_code;
          digit_cnt_d = 3'd1;
        end
      end
      S_ENTRY: begin
        // An accepted key outranks a coincident timeout tick.
        if (key_valid && (key_code <= 4'hB)) begin
          sec_d = '0;
          if (key_digit) begin
            if (digit_cnt_q < 3'd4) begin
              digits_d[digit_cnt_q[1:0]] = key_code;
              digit_cnt_d = digit_cnt_q + 3'd1;
            end
          end else if (key_code == 4'hA) begin
            if (code_ok) begin
              state_d  = S_GRANTED;
              fail_d   = '0;
              unlock_d = 1'b1;
            end else begin
              state_d = S_DENIED;
              if (fail_q != 2'd3) fail_d = fail_q + 2'd1;
            end
          end else begin
            state_d = S_PROMPT;
          end
        end else if (tick && (sec_q == ENTRY_LAST)) begin
          state_d = S_PROMPT;
        end
      end
      S_GRANTED: begin
        if (tick && (sec_q == GRANT_LAST))
          state_d = (fail_q == FAIL_LIMIT) ? S_LOCKED : S_PROMPT;
      end
      S_DENIED: begin
        if (tick && (sec_q == DENY_LAST))
          state_d = (fail_q == FAIL_LIMIT) ? S_LOCKED : S_PROMPT;
      end
      S_LOCKED: begin
        if (tick && (sec_q == LOCK_LAST)) begin
          state_d = S_PROMPT;
          fail_d  = '0;
        end
      end
      default: state_d = S_PROMPT;
    endcase

    // Every state change restarts the second phase so timed states last whole seconds.
    if (state_d != state_q) begin
      tick_cnt_d = '0;
      sec_d      = '0;
      blink_d    = 1'b0;
      if (state_d != S_ENTRY) begin
        digits_d    = '0;
        digit_cnt_d = '0;
      end
    end
  end

  logic [2:0] slot;
  assign slot = col_idx - 3'd2;

  always_comb begin
    col_char = 7'h00;
    unique case (state_q)
      S_PROMPT: begin
        if (!blink_q) begin
          case (col_idx)
            3'd0: col_char = 7'h50;
            3'd1: col_char = 7'h41;
            3'd2: col_char = 7'h53;
            3'd3: col_char = 7'h53;
            3'd4: col_char = 7'h57;
            3'd5: col_char = 7'h4F;
            3'd6: col_char = 7'h52;
            default: col_char = 7'h44;
          endcase
        end else if ((col_idx >= 3'd2) && (col_idx <= 3'd5)) begin
          col_char = 7'h2D;
        end
      end
      S_ENTRY: begin
        if ((col_idx >= 3'd2) && (col_idx <= 3'd5))
          col_char = (slot < digit_cnt_q) ? 7'h2A : 7'h2D;
      end
      S_GRANTED: begin
        case (col_idx)
          3'd2: col_char = 7'h4F;
          3'd3: col_char = 7'h50;
          3'd4: col_char = 7'h45;
          3'd5: col_char = 7'h4E;
          default: col_char = 7'h00;
        endcase
      end
      S_DENIED: begin
        case (col_idx)
          3'd1: col_char = 7'h44;
          3'd2: col_char = 7'h45;
          3'd3: col_char = 7'h4E;
          3'd4: col_char = 7'h49;
          3'd5: col_char = 7'h45;
          3'd6: col_char = 7'h44;
          default: col_char = 7'h00;
        endcase
      end
      S_LOCKED: begin
        case (col_idx)
          3'd1: col_char = 7'h4C;
          3'd2: col_char = 7'h4F;
          3'd3: col_char = 7'h43;
          3'd4: col_char = 7'h4B;
          3'd5: col_char = 7'h45;
          3'd6: col_char = 7'h44;
          default: col_char = 7'h00;
        endcase
      end
      default: col_char = 7'h00;
    endcase
  end

  assign state    = state_q;
  assign fail_cnt = fail_q;
  assign unlock   = unlock_q;
  assign locked   = (state_q == S_LOCKED);

endmodule

// File: tb/tb_pass_entry_ctrl.sv
// tb/tb_pass_entry_ctrl.sv - randomized and directed bench for pass_entry_ctrl against a timeline model
`timescale 1ns/100ps
module tb_pass_entry_ctrl;

  localparam int T        = 4;
  localparam logic [15:0] CODE = 16'h1234;
  localparam int MAXF     = 3;
  localparam int ENTRY_TO = 10;
  localparam int GRANT_S  = 3;
  localparam int DENY_S   = 2;
  localparam int LOCK_S   = 5;

  logic       main_clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] col_idx;
  logic [6:0] col_char;
  logic       unlock;
  logic       locked;
  logic [2:0] state;
  logic [1:0] fail_cnt;

  pass_entry_ctrl #(
    .TICKS_PER_SEC(T), .CODE(CODE), .MAX_FAILS(MAXF), .ENTRY_TIMEOUT(ENTRY_TO),
    .GRANT_SECS(GRANT_S), .DENY_SECS(DENY_S), .LOCK_SECS(LOCK_S)
  ) dut (
    .main_clk(main_clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .col_idx(col_idx), .col_char(col_char), .unlock(unlock), .locked(locked),
    .state(state), .fail_cnt(fail_cnt)
  );

  initial main_clk = 1'b0;
  always #10 main_clk = ~main_clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: state plus elapsed edges since entry; timers are derived arithmetically.
  int m_st;
  int m_age;
  int m_key_age;
  int m_fails;
  bit m_unlock;
  int m_dig[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_age = 0; m_key_age = -1; m_fails = 0; m_unlock = 0;
    m_dig.delete();
  endtask

  function automatic logic [6:0] exp_col(input int c);
    string s;
    byte   b;
    case (m_st)
      0: s = (((m_age / T) % 2) == 1) ? "  ----  " : "PASSWORD";
      1: begin
        if (c >= 2 && c <= 5) return ((c - 2) < m_dig.size()) ? 7'h2A : 7'h2D;
        return 7'h00;
      end
      2: s = "  OPEN  ";
      3: s = " DENIED ";
      4: s = " LOCKED ";
      default: s = "        ";
    endcase
    b = s[c];
    return (b == 8'h20) ? 7'h00 : b[6:0];
  endfunction

  task automatic model_step(input bit kv, input logic [3:0] kc);
    int  nst = m_st;
    int  k   = int'(kc);
    int  val;
    bit  acc = 0;
    m_unlock = 0;
    case (m_st)
      0: if (kv && k <= 9) begin nst = 1; m_dig.delete(); m_dig.push_back(k); end
      1: begin
        if (kv && k <= 11) begin
          acc = 1;
          if (k <= 9) begin
            if (m_dig.size() < 4) m_dig.push_back(k);
          end else if (k == 10) begin
            val = -1;
            if (m_dig.size() == 4) val = (m_dig[0] << 12) | (m_dig[1] << 8) | (m_dig[2] << 4) | m_dig[3];
            if (val == int'(CODE)) begin nst = 2; m_fails = 0; m_unlock = 1; end
            else begin nst = 3; if (m_fails < 3) m_fails++; end
          end else begin
            nst = 0;
          end
        end else if ((m_age % T == T - 1) &&
                     (((m_age + 1) / T) - ((m_key_age + 1) / T) == ENTRY_TO)) begin
          nst = 0;
        end
      end
      2: if (m_age + 1 == GRANT_S * T) nst = (m_fails == MAXF) ? 4 : 0;
      3: if (m_age + 1 == DENY_S * T)  nst = (m_fails == MAXF) ? 4 : 0;
      4: if (m_age + 1 == LOCK_S * T) begin nst = 0; m_fails = 0; end
      default: nst = 0;
    endcase
    if (acc) m_key_age = m_age;
    if (nst != m_st) begin
      m_st = nst; m_age = 0; m_key_age = -1;
      if (nst != 1) m_dig.delete();
    end else begin
      m_age++;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".state"}, 32'(state), 32'(m_st));
    check({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(m_fails));
    check({tag, ".unlock"}, 32'(unlock), 32'(m_unlock));
    check({tag, ".locked"}, 32'(locked), 32'(m_st == 4));
    check({tag, ".col_char"}, 32'(col_char), 32'(exp_col(int'(col_idx))));
  endtask

  // Called just after a check point; drives inputs, advances one edge, checks.
  task automatic cycle(input bit kv, input logic [3:0] kc, input string tag);
    key_valid = kv;
    key_code  = kc;
    col_idx   = 3'($urandom_range(0, 7));
    model_step(kv, kc);
    @(posedge main_clk);
    #1;
    key_valid = 1'b0;
    compare_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, tag);
  endtask

  task automatic keys(input logic [3:0] seq[$], input string tag);
    foreach (seq[i]) cycle(1'b1, seq[i], tag);
  endtask

  task automatic sweep(input string tag);
    for (int c = 0; c < 8; c++) begin
      col_idx = 3'(c);
      #1;
      check({tag, ".sweep"}, 32'(col_char), 32'(exp_col(c)));
    end
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    key_valid = 1'b0;
    col_idx = 3'd0;
    model_reset();
    #1;
    compare_all(tag);
    check({tag, ".col0"}, 32'(col_char), 32'h50);
    @(negedge main_clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; col_idx = 3'd0;
    model_reset();
    #5;
    compare_all("reset");
    check("reset.col0", 32'(col_char), 32'h50);
    #10;
    rst = 1'b0;

    // 1: blink alternation, non-digit keys ignored in PROMPT
    sweep("t1a");
    idle(4, "t1");
    sweep("t1b");
    cycle(1'b1, 4'hA, "t1.enter");
    cycle(1'b1, 4'hB, "t1.clear");
    cycle(1'b1, 4'hC, "t1.ign");
    idle(1, "t1");
    sweep("t1c");
    idle(3, "t1");

    // 2: correct code, grant for 3 s
    keys('{4'h1, 4'h2, 4'h3}, "t2.dig");
    sweep("t2");
    keys('{4'h4, 4'hA}, "t2.ent");
    sweep("t2g");
    idle(GRANT_S * T, "t2.hold");

    // 3: three denials into lockout, keys ignored while locked
    for (int r = 0; r < 3; r++) begin
      keys('{4'h1, 4'h2, 4'h3, 4'h5, 4'hA}, "t3.deny");
      idle(DENY_S * T, "t3.wait");
    end
    sweep("t3l");
    for (int i = 0; i < LOCK_S * T; i++) cycle(1'b1, 4'($urandom_range(0, 11)), "t3.lock");

    // 4: short entry, clear, then overlong entry with dropped fifth digit
    keys('{4'h1, 4'h2, 4'hA}, "t4.short");
    idle(DENY_S * T, "t4.wait");
    keys('{4'h7, 4'hB}, "t4.clr");
    keys('{4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hA}, "t4.five");
    idle(GRANT_S * T, "t4.hold");

    // 5: entry timeout, then a key on the timeout tick keeps ENTRY
    cycle(1'b1, 4'h3, "t5.key");
    idle(ENTRY_TO * T, "t5.to");
    cycle(1'b1, 4'h3, "t5.key2");
    idle(ENTRY_TO * T - 1, "t5.almost");
    cycle(1'b1, 4'h5, "t5.race");
    idle(6, "t5.after");
    cycle(1'b1, 4'hB, "t5.clr");

    // 6: async reset mid-GRANTED and mid-LOCKED
    keys('{4'h1, 4'h2, 4'h3, 4'h4, 4'hA}, "t6.grant");
    idle(5, "t6.g");
    async_reset("t6.rst_g");
    idle(2, "t6.post");
    for (int r = 0; r < 3; r++) begin
      keys('{4'h9, 4'hA}, "t6.deny");
      idle(DENY_S * T, "t6.wait");
    end
    idle(7, "t6.l");
    async_reset("t6.rst_l");
    idle(2, "t6.post2");

    // Random traffic, biased toward the correct code so grants occur
    for (int i = 0; i < 3000; i++) begin
      bit kv = ($urandom_range(0, 2) == 0);
      logic [3:0] kc;
      if (m_dig.size() < 4 && $urandom_range(0, 1) == 1)
        kc = 4'((int'(CODE) >> (12 - 4 * m_dig.size())) & 15);
      else
        kc = 4'($urandom_range(0, 11));
      cycle(kv, kc, "rand");
      if ((i % 97) == 0) sweep("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
